logic_unit_pipe: RTL and testbench
==================================

# logic_unit_pipe

Parametrised, two-stage pipelined bitwise logic unit for the integer ALU. It replaces the fixed 4-bit combinational gate blocks (AND/OR/NAND/NOR/XOR/XNOR/NOT) with one opcode-selected unit that has a valid/ready handshake on both sides and an accumulator mode that chains results. It also produces result flags and a completed-operation counter. It sits between the ALU operand decode and the ALU result mux.

## Interface
- WIDTH, 4, operand/result width in bits (≥1)
- CNT_W, 16, width of completed-operation counter

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input operation valid
- in_ready  out  1  unit can accept input this cycle
- op  in  3  opcode: 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR, 110 NOT a, 111 pass b
- a  in  WIDTH  operand A (ignored when acc_en=1)
- b  in  WIDTH  operand B
- acc_en  in  1  sampled with input; use accumulator in place of a
- acc_clr  in  1  synchronous accumulator clear (independent of handshake)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result  out  WIDTH  operation result
- zero  out  1  result == 0
- ones  out  1  result == all ones
- parity  out  1  XOR-reduce of result
- op_count  out  CNT_W  number of results accepted downstream

## Operation
- Stage 1 (S1) register: op, a, b, acc_en, s1_valid. Loads on in_valid && in_ready.
- Stage 2 (S2) register: result, zero, ones, parity, s2_valid. Loads from S1 when s1_valid && s1_ready.
- Compute happens on the S1→S2 transfer: operand A = acc_en ? acc : a (S1 copies).
- Accumulator acc (WIDTH bits): on every S1→S2 transfer, acc ← computed result, regardless of acc_en.
- acc_clr=1: acc ← 0 at that edge; clear has priority over a same-cycle update. An operation transferring in the same cycle still uses the pre-clear acc value as operand.
- Flags are registered with result in S2; flags are computed from the new result, not recomputed from output.
- op_count increments on out_valid && out_ready; wraps from 2^CNT_W−1 to 0.
- NOT a ignores b; pass b ignores A (and acc_en only affects acc update via result).

## Timing
- Reset (rst_n=0, asynchronous): s1_valid=0, s2_valid=0, out_valid=0, result=0, zero=1, ones=0, parity=0, acc=0, op_count=0. in_ready=1 immediately once reset is released (in_ready is combinational, and 1 during reset as well).
- s1_ready = !s2_valid || out_ready; in_ready = !s1_valid || s1_ready (combinational, no skid).
- Latency: input accepted at edge N → out_valid=1 after edge N+1 (visible cycle N+1 onward).
- Throughput: one op per cycle with out_ready held high.
- Backpressure: out_ready=0 with S2 full holds result/flags stable; S1 then fills and in_ready drops in the following cycle; no data lost or duplicated.
- S2 drains and S1 moves up in the same edge when out_ready=1; S1 simultaneously accepts new input.
- Back-to-back acc_en ops see the result of the immediately previous transferred op (no bubble needed).
- Reset asserted mid-operation discards all in-flight ops; op_count is not incremented for them.
- Outputs change only on clk rising edge or rst_n falling edge; in_ready is the only combinational output.

## Test plan
- Reset then WIDTH=4, op=010 NAND, a=1010 b=1100 → two cycles later result=0111, zero=0, ones=0, parity=1; op_count=1 after handshake.
- Stream of ops AND(1111,0001)=0001, OR(1010,0101)=1111 (ones=1), XOR(1111,1111)=0000 (zero=1), XNOR(1010,1100)=1001, with out_ready=1 → one result per cycle in order, op_count=4.
- Accumulator chain: pass b 0011, then acc_en XOR b=0101 → 0110, then acc_en NOT → 1001; then acc_clr with acc_en OR b=0000 transferring same cycle → result 1001, next acc_en OR b=0000 → 0000.
- Backpressure: out_ready=0 for 5 cycles while driving 3 ops → out_valid held with first result stable, in_ready=0 after S1 fills, all 3 results emitted in order once out_ready=1.
- Reset mid-flight with 2 ops in pipe → out_valid=0, result=0, zero=1, acc=0, op_count unchanged at 0 after release.
- CNT_W=2: complete 5 ops → op_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/logic_unit_pipe_if.sv
// Handshake and data bundle for logic_unit_pipe: operation request in, result plus flags out.
// The master drives operations and downstream ready; the slave is the pipelined unit.
interface logic_unit_pipe_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             acc_en;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             ones;
  logic             parity;
  logic [CNT_W-1:0] op_count;

  modport master (
    output in_valid, op, a, b, acc_en, acc_clr, out_ready,
    input  in_ready, out_valid, result, zero, ones, parity, op_count
  );

  modport slave (
    input  in_valid, op, a, b, acc_en, acc_clr, out_ready,
    output in_ready, out_valid, result, zero, ones, parity, op_count
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with accumulator chaining, result flags
// and a completed-operation counter; valid/ready handshake on both sides.
module logic_unit_pipe #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  logic_unit_pipe_if.slave  bus
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_NOTA = 3'b110;

  // S1: captured operation
  logic [2:0]       s1_op_reg;
  logic [WIDTH-1:0] s1_a_reg;
  logic [WIDTH-1:0] s1_b_reg;
  logic             s1_acc_en_reg;
  logic             s1_valid_reg;

  // S2: result and flags
  logic [WIDTH-1:0] result_reg;
  logic             zero_reg;
  logic             ones_reg;
  logic             parity_reg;
  logic             s2_valid_reg;

  logic [WIDTH-1:0] acc_reg;
  logic [CNT_W-1:0] op_count_reg;

  logic             s1_ready;
  logic             in_fire;
  logic             s1_fire;
  logic             out_fire;
  logic [WIDTH-1:0] opnd_a;
  logic [WIDTH-1:0] calc_result;

  assign s1_ready = !s2_valid_reg || bus.out_ready;
  assign in_fire  = bus.in_valid && bus.in_ready;
  assign s1_fire  = s1_valid_reg && s1_ready;
  assign out_fire = s2_valid_reg && bus.out_ready;

  // acc is read before any same-edge clear or update takes effect
  assign opnd_a = s1_acc_en_reg ? acc_reg : s1_a_reg;

  function automatic logic bit_op(input logic [2:0] op, input logic x, input logic y);
    logic r;
    case (op)
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_NAND: r = ~(x & y);
      OP_NOR:  r = ~(x | y);
      OP_XOR:  r = x ^ y;
      OP_XNOR: r = ~(x ^ y);
      OP_NOTA: r = ~x;
      default: r = y;
    endcase
    return r;
  endfunction

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign calc_result[gi] = bit_op(s1_op_reg, opnd_a[gi], s1_b_reg[gi]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_op_reg     <= '0;
      s1_a_reg      <= '0;
      s1_b_reg      <= '0;
      s1_acc_en_reg <= 1'b0;
      s1_valid_reg  <= 1'b0;
    end else if (in_fire) begin
      s1_op_reg     <= bus.op;
      s1_a_reg      <= bus.a;
      s1_b_reg      <= bus.b;
      s1_acc_en_reg <= bus.acc_en;
      s1_valid_reg  <= 1'b1;
    end else if (s1_fire) begin
      s1_valid_reg  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_reg   <= '0;
      zero_reg     <= 1'b1;
      ones_reg     <= 1'b0;
      parity_reg   <= 1'b0;
      s2_valid_reg <= 1'b0;
    end else if (s1_fire) begin
      result_reg   <= calc_result;
      zero_reg     <= ~|calc_result;
      ones_reg     <= &calc_result;
      parity_reg   <= ^calc_result;
      s2_valid_reg <= 1'b1;
    end else if (out_fire) begin
      s2_valid_reg <= 1'b0;
    end
  end

  // Clear wins over the chaining update on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
    end else if (bus.acc_clr) begin
      acc_reg <= '0;
    end else if (s1_fire) begin
      acc_reg <= calc_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_reg <= '0;
    end else if (out_fire) begin
      op_count_reg <= op_count_reg + 1'b1;
    end
  end

  assign bus.in_ready  = !s1_valid_reg || s1_ready;
  assign bus.out_valid = s2_valid_reg;
  assign bus.result    = result_reg;
  assign bus.zero      = zero_reg;
  assign bus.ones      = ones_reg;
  assign bus.parity    = parity_reg;
  assign bus.op_count  = op_count_reg;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: a 4-bit/16-bit-counter unit for function and
// flow control, and a 2-bit-counter unit for counter wrap.
module tb_logic_unit_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  logic_unit_pipe_if #(.WIDTH(4), .CNT_W(16)) bus ();
  logic_unit_pipe_if #(.WIDTH(4), .CNT_W(2))  bus2 ();

  logic_unit_pipe #(.WIDTH(4), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic_unit_pipe #(.WIDTH(4), .CNT_W(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input logic v, input logic [2:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic acc_en);
    bus.in_valid = v;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    bus.acc_en   = acc_en;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== 4'b0000 || bus.zero !== 1'b1 ||
        bus.ones !== 1'b0 || bus.parity !== 1'b0 || bus.op_count !== 16'd0 ||
        bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: ov=%b res=%b z=%b o=%b p=%b cnt=%0d rdy=%b, want ov=0 res=0000 z=1 o=0 p=0 cnt=0 rdy=1",
               bus.out_valid, bus.result, bus.zero, bus.ones, bus.parity, bus.op_count, bus.in_ready);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: rdy=%b ov=%b, want rdy=1 ov=0", bus.in_ready, bus.out_valid);
    end
    $display("reset: done");
  endtask

  task automatic test_nand_latency();
    set_in(1'b1, 3'b010, 4'b1010, 4'b1100, 1'b0);
    step();
    set_in(1'b0, 3'b000, 4'b0000, 4'b0000, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL nand_latency_early: ov=%b want 0", bus.out_valid);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 4'b0111 || bus.zero !== 1'b0 ||
        bus.ones !== 1'b0 || bus.parity !== 1'b1) begin
      errors++;
      $display("FAIL nand_result: ov=%b res=%b z=%b o=%b p=%b, want ov=1 res=0111 z=0 o=0 p=1",
               bus.out_valid, bus.result, bus.zero, bus.ones, bus.parity);
    end
    step();
    checks++;
    if (bus.op_count !== 16'd1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL nand_count: cnt=%0d ov=%b, want cnt=1 ov=0", bus.op_count, bus.out_valid);
    end
    $display("nand: res=%b cnt=%0d", bus.result, bus.op_count);
  endtask

  task automatic test_stream();
    logic [2:0] ops[4] = '{3'b000, 3'b001, 3'b100, 3'b101};
    logic [3:0] av[4]  = '{4'b1111, 4'b1010, 4'b1111, 4'b1010};
    logic [3:0] bv[4]  = '{4'b0001, 4'b0101, 4'b1111, 4'b1100};
    logic [3:0] ev[4]  = '{4'b0001, 4'b1111, 4'b0000, 4'b1001};
    logic [2:0] ef[4]  = '{3'b001, 3'b010, 3'b100, 3'b000};
    bus.out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      checks++;
      if (c >= 2 && c < 6) begin
        if (bus.out_valid !== 1'b1 || bus.result !== ev[c-2] ||
            {bus.zero, bus.ones, bus.parity} !== ef[c-2] || bus.in_ready !== 1'b1) begin
          errors++;
          $display("FAIL stream_%0d: ov=%b res=%b zop=%b rdy=%b, want ov=1 res=%b zop=%b rdy=1",
                   c - 2, bus.out_valid, bus.result, {bus.zero, bus.ones, bus.parity},
                   bus.in_ready, ev[c-2], ef[c-2]);
        end else begin
          $display("stream: result %0d = %b", c - 2, bus.result);
        end
      end else if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL stream_idle_%0d: ov=%b want 0", c, bus.out_valid);
      end
      if (c < 4) set_in(1'b1, ops[c], av[c], bv[c], 1'b0);
      else       set_in(1'b0, 3'b000, 4'b0000, 4'b0000, 1'b0);
      step();
    end
    checks++;
    if (bus.op_count !== 16'd5) begin
      errors++;
      $display("FAIL stream_count: cnt=%0d want 5", bus.op_count);
    end
  endtask

  task automatic test_acc_chain();
    logic [2:0] ops[5] = '{3'b111, 3'b100, 3'b110, 3'b001, 3'b001};
    logic [3:0] bv[5]  = '{4'b0011, 4'b0101, 4'b0000, 4'b0000, 4'b0000};
    logic       ae[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0] ev[5]  = '{4'b0011, 4'b0110, 4'b1001, 4'b1001, 4'b0000};
    bus.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c >= 2 && c < 7) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.result !== ev[c-2]) begin
          errors++;
          $display("FAIL acc_chain_%0d: ov=%b res=%b, want ov=1 res=%b",
                   c - 2, bus.out_valid, bus.result, ev[c-2]);
        end else begin
          $display("acc_chain: result %0d = %b", c - 2, bus.result);
        end
      end
      // clear lands on the edge where the fourth op moves S1 -> S2
      bus.acc_clr = (c == 4);
      if (c < 5) set_in(1'b1, ops[c], 4'b1111, bv[c], ae[c]);
      else       set_in(1'b0, 3'b000, 4'b0000, 4'b0000, 1'b0);
      step();
    end
    bus.acc_clr = 1'b0;
    checks++;
    if (bus.op_count !== 16'd10) begin
      errors++;
      $display("FAIL acc_chain_count: cnt=%0d want 10", bus.op_count);
    end
  endtask

  task automatic test_backpressure();
    logic [2:0] ops[3] = '{3'b011, 3'b001, 3'b100};
    logic [3:0] av[3]  = '{4'b1100, 4'b0001, 4'b0110};
    logic [3:0] bv[3]  = '{4'b1010, 4'b0010, 4'b0011};
    logic       ordy[9] = '{0, 0, 0, 0, 0, 1, 1, 1, 1};
    int         opi[9]  = '{0, 1, 2, 2, 2, 2, -1, -1, -1};
    logic       erdy[9] = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
    logic       eov[9]  = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
    logic [3:0] eres[9] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001,
                            4'b0001, 4'b0011, 4'b0101, 4'b0000};
    for (int c = 0; c < 9; c++) begin
      bus.out_ready = ordy[c];
      if (opi[c] >= 0) set_in(1'b1, ops[opi[c]], av[opi[c]], bv[opi[c]], 1'b0);
      else             set_in(1'b0, 3'b000, 4'b0000, 4'b0000, 1'b0);
      #1;
      checks++;
      if (bus.in_ready !== erdy[c] || bus.out_valid !== eov[c] ||
          (eov[c] && bus.result !== eres[c])) begin
        errors++;
        $display("FAIL backpressure_%0d: rdy=%b ov=%b res=%b, want rdy=%b ov=%b res=%b",
                 c, bus.in_ready, bus.out_valid, bus.result, erdy[c], eov[c], eres[c]);
      end else begin
        $display("backpressure: cycle %0d rdy=%b ov=%b res=%b", c, bus.in_ready, bus.out_valid, bus.result);
      end
      step();
    end
    checks++;
    if (bus.op_count !== 16'd13) begin
      errors++;
      $display("FAIL backpressure_count: cnt=%0d want 13", bus.op_count);
    end
  endtask

  task automatic test_reset_midflight();
    bus.out_ready = 1'b0;
    set_in(1'b1, 3'b111, 4'b0000, 4'b1111, 1'b0);
    step();
    step();
    set_in(1'b0, 3'b000, 4'b0000, 4'b0000, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== 4'b0000 || bus.zero !== 1'b1 ||
        bus.op_count !== 16'd0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midflight_reset: ov=%b res=%b z=%b cnt=%0d rdy=%b, want ov=0 res=0000 z=1 cnt=0 rdy=1",
               bus.out_valid, bus.result, bus.zero, bus.op_count, bus.in_ready);
    end
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.op_count !== 16'd0) begin
      errors++;
      $display("FAIL midflight_flush: ov=%b cnt=%0d, want ov=0 cnt=0", bus.out_valid, bus.op_count);
    end
    // a cleared acc makes acc XOR b equal b
    set_in(1'b1, 3'b100, 4'b1111, 4'b0101, 1'b1);
    step();
    set_in(1'b0, 3'b000, 4'b0000, 4'b0000, 1'b0);
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 4'b0101) begin
      errors++;
      $display("FAIL midflight_acc: ov=%b res=%b, want ov=1 res=0101", bus.out_valid, bus.result);
    end
    step();
    checks++;
    if (bus.op_count !== 16'd1) begin
      errors++;
      $display("FAIL midflight_count: cnt=%0d want 1", bus.op_count);
    end
    $display("midflight: acc op res=0101 cnt=%0d", bus.op_count);
  endtask

  task automatic test_count_wrap();
    logic [1:0] ecnt[8] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    bus2.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (bus2.op_count !== ecnt[c]) begin
        errors++;
        $display("FAIL count_wrap_%0d: cnt=%0d want %0d", c, bus2.op_count, ecnt[c]);
      end else begin
        $display("count_wrap: cycle %0d cnt=%0d", c, bus2.op_count);
      end
      bus2.in_valid = (c < 5);
      bus2.op       = 3'b111;
      bus2.b        = 4'(c);
      step();
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.op = 3'b000; bus.a = '0; bus.b = '0;
    bus.acc_en = 1'b0; bus.acc_clr = 1'b0; bus.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.op = 3'b000; bus2.a = '0; bus2.b = '0;
    bus2.acc_en = 1'b0; bus2.acc_clr = 1'b0; bus2.out_ready = 1'b1;
    test_reset();
    test_nand_latency();
    test_stream();
    test_acc_chain();
    test_backpressure();
    test_reset_midflight();
    test_count_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, want completion");
    $fatal(1, "timeout");
  end

endmodule
